// File: rtl/fft_out_reorder_if.sv
// rtl/fft_out_reorder_if.sv - lane inputs and reordered-bin outputs of the FFT output reorder block
interface fft_out_reorder_if #(
  parameter int NBITS = 21
);
  // Four parallel FFT lanes, bit-reversed bin order, {re, im} per word
  logic [2*NBITS-1:0] fftIn0_up;
  logic [2*NBITS-1:0] fftIn0_down;
  logic [2*NBITS-1:0] fftIn1_up;
  logic [2*NBITS-1:0] fftIn1_down;
  logic               in_enable;

  // Natural-order bins 4r+0 .. 4r+3 and their qualifiers
  logic [2*NBITS-1:0] out0;
  logic [2*NBITS-1:0] out1;
  logic [2*NBITS-1:0] out2;
  logic [2*NBITS-1:0] out3;
  logic               o_enable;
  logic               o_frame_start;
  logic               o_overrun;

  // Producer of lane data / consumer of reordered bins
  modport master (
    output fftIn0_up, fftIn0_down, fftIn1_up, fftIn1_down, in_enable,
    input  out0, out1, out2, out3, o_enable, o_frame_start, o_overrun
  );

  // The reorder block itself
  modport slave (
    input  fftIn0_up, fftIn0_down, fftIn1_up, fftIn1_down, in_enable,
    output out0, out1, out2, out3, o_enable, o_frame_start, o_overrun
  );
endinterface

// File: rtl/fft_out_reorder.sv
// rtl/fft_out_reorder.sv - ping-pong buffer turning bit-reversed FFT lanes into natural-order bins
module fft_out_reorder #(
  parameter int N     = 128,
  parameter int NBITS = 21
) (
  input  logic              clk,
  input  logic              rst,
  fft_out_reorder_if.slave  bus
);

  localparam int LOG2N = $clog2(N);
  localparam int BEATS = N / 4;
  localparam int CW    = LOG2N - 2;
  localparam int W     = 2 * NBITS;
  localparam logic [CW-1:0] LAST = CW'(BEATS - 1);

  typedef logic [W-1:0] word_t;
  typedef enum logic {IDLE, READ} state_t;

  function automatic logic [LOG2N-1:0] bitrev(input logic [LOG2N-1:0] a);
    logic [LOG2N-1:0] r;
    for (int i = 0; i < LOG2N; i++) r[i] = a[LOG2N-1-i];
    return r;
  endfunction

  // Two banks of N words; the top address bit selects the bank
  word_t mem_q [2*N];

  word_t         lane_w [4];
  logic [CW-1:0] wc_q, wc_d;
  logic          wbank_q, wbank_d;
  logic          frame_ready;

  state_t        state_q, state_d;
  logic [CW-1:0] rc_q, rc_d;
  logic          rbank_q, rbank_d;
  word_t         out_q [4];
  word_t         out_d [4];
  logic          en_q, en_d;
  logic          fs_q, fs_d;
  logic          overrun_q, overrun_d;

  assign lane_w[0] = bus.fftIn0_up;
  assign lane_w[1] = bus.fftIn0_down;
  assign lane_w[2] = bus.fftIn1_up;
  assign lane_w[3] = bus.fftIn1_down;

  // Writer: beat counter and bank flip; frame_ready marks the last beat of a frame
  always_comb begin
    wc_d        = wc_q;
    wbank_d     = wbank_q;
    frame_ready = 1'b0;
    if (bus.in_enable) begin
      if (wc_q == LAST) begin
        frame_ready = 1'b1;
        wc_d        = '0;
        wbank_d     = ~wbank_q;
      end else begin
        wc_d = wc_q + CW'(1);
      end
    end
  end

  // Writer state registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wc_q    <= '0;
      wbank_q <= 1'b0;
    end else begin
      wc_q    <= wc_d;
      wbank_q <= wbank_d;
    end
  end

  // Buffer write: lane l of beat wc lands at the bit-reversed address of bin 4*wc+l
  always_ff @(posedge clk) begin
    if (bus.in_enable) begin
      for (int l = 0; l < 4; l++) begin
        mem_q[{wbank_q, bitrev({wc_q, 2'(l)})}] <= lane_w[l];
      end
    end
  end

  // Reader: drain the completed bank in natural order, chaining straight into the next frame
  always_comb begin
    state_d   = state_q;
    rc_d      = rc_q;
    rbank_d   = rbank_q;
    overrun_d = overrun_q;
    en_d      = 1'b0;
    fs_d      = 1'b0;
    for (int l = 0; l < 4; l++) out_d[l] = out_q[l];
    case (state_q)
      IDLE: begin
        if (frame_ready) begin
          state_d = READ;
          rc_d    = '0;
          rbank_d = wbank_q;
        end
      end
      READ: begin
        en_d = 1'b1;
        fs_d = (rc_q == '0);
        for (int l = 0; l < 4; l++) out_d[l] = mem_q[{rbank_q, rc_q, 2'(l)}];
        if (frame_ready) begin
          // A frame landing before this one is fully read means data was lost
          if (rc_q != LAST) overrun_d = 1'b1;
          rc_d    = '0;
          rbank_d = wbank_q;
        end else if (rc_q == LAST) begin
          state_d = IDLE;
        end else begin
          rc_d = rc_q + CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Reader state and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      rc_q      <= '0;
      rbank_q   <= 1'b0;
      en_q      <= 1'b0;
      fs_q      <= 1'b0;
      overrun_q <= 1'b0;
      for (int l = 0; l < 4; l++) out_q[l] <= '0;
    end else begin
      state_q   <= state_d;
      rc_q      <= rc_d;
      rbank_q   <= rbank_d;
      en_q      <= en_d;
      fs_q      <= fs_d;
      overrun_q <= overrun_d;
      for (int l = 0; l < 4; l++) out_q[l] <= out_d[l];
    end
  end

  assign bus.out0          = out_q[0];
  assign bus.out1          = out_q[1];
  assign bus.out2          = out_q[2];
  assign bus.out3          = out_q[3];
  assign bus.o_enable      = en_q;
  assign bus.o_frame_start = fs_q;
  assign bus.o_overrun     = overrun_q;

endmodule
